// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: mode encodings and fixed-point angle/gain tables.
// Values are computed at elaboration time from the fractional-bit count.
package cordic_pkg;

  typedef logic [1:0] cordic_mode_t;

  localparam cordic_mode_t CORDIC_SINCOS = 2'b00;
  localparam cordic_mode_t CORDIC_VECT   = 2'b01;
  localparam cordic_mode_t CORDIC_ROT    = 2'b10;
  localparam cordic_mode_t CORDIC_RSVD   = 2'b11;

  function automatic real fx_one(input int frac);
    return real'(longint'(1) << frac);
  endfunction

  // round(atan(2^-i) * 2^frac), clamped to the positive range of a w-bit word
  function automatic longint atan_lut(input int i, input int frac, input int w);
    real    t;
    longint v;
    longint lim;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    v   = longint'($atan(t) * fx_one(frac));
    lim = (longint'(1) << (w - 1)) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic longint k_inv(input int frac);
    return longint'(0.607252935 * fx_one(frac));
  endfunction

  function automatic longint pi_fx(input int frac);
    return longint'(3.14159265358979323846 * fx_one(frac));
  endfunction

  function automatic longint half_pi_fx(input int frac);
    return longint'(1.57079632679489661923 * fx_one(frac));
  endfunction

endpackage

// File: rtl/cordic_stream_if.sv
// Request/result stream bundle of the CORDIC engine; master is the producer/consumer side.
// Both directions use valid/ready; busy reports any in-flight work.
interface cordic_stream_if
  import cordic_pkg::*;
#(
  parameter int DW   = 32,
  parameter int TAGW = 4
) ();
  logic              in_valid;
  logic              in_ready;
  cordic_mode_t      in_mode;
  logic [DW-1:0]     in_x;
  logic [DW-1:0]     in_y;
  logic [DW-1:0]     in_z;
  logic [TAGW-1:0]   in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_a;
  logic [DW-1:0]     out_b;
  logic [TAGW-1:0]   out_tag;
  logic              out_err;
  logic              busy;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_tag, out_err, busy
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    output in_ready, out_valid, out_a, out_b, out_tag, out_err, busy
  );
endinterface

// File: rtl/cordic_iter_stage.sv
// One registered CORDIC micro-rotation by atan(2^-SHIFT); latency 1 cycle.
// Holds its contents while en is low; sideband fields ride along unchanged.
module cordic_iter_stage
  import cordic_pkg::*;
#(
  parameter int                  W     = 34,
  parameter int                  SHIFT = 0,
  parameter logic signed [W-1:0] ATAN  = '0,
  parameter int                  TAGW  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                prev_valid,
  input  cordic_mode_t        prev_mode,
  input  logic                prev_flip,
  input  logic [TAGW-1:0]     prev_tag,
  input  logic signed [W-1:0] prev_x,
  input  logic signed [W-1:0] prev_y,
  input  logic signed [W-1:0] prev_z,
  output logic                next_valid,
  output cordic_mode_t        next_mode,
  output logic                next_flip,
  output logic [TAGW-1:0]     next_tag,
  output logic signed [W-1:0] next_x,
  output logic signed [W-1:0] next_y,
  output logic signed [W-1:0] next_z
);
  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic                ccw;

  assign x_sh = prev_x >>> SHIFT;
  assign y_sh = prev_y >>> SHIFT;
  // Rotation modes chase z to zero; vectoring chases y to zero.
  assign ccw  = (prev_mode == CORDIC_VECT) ? prev_y[W-1] : !prev_z[W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_valid <= 1'b0;
    end else if (en) begin
      next_valid <= prev_valid;
      next_mode  <= prev_mode;
      next_flip  <= prev_flip;
      next_tag   <= prev_tag;
      if (ccw) begin
        next_x <= prev_x - y_sh;
        next_y <= prev_y + x_sh;
        next_z <= prev_z - ATAN;
      end else begin
        next_x <= prev_x + y_sh;
        next_y <= prev_y - x_sh;
        next_z <= prev_z + ATAN;
      end
    end
  end
endmodule

// File: rtl/cordic_stream_top.sv
// Pipelined CORDIC (sin/cos, atan2+magnitude, rotation); latency ITER+2 cycles, one beat per cycle.
// Whole pipe freezes while a result is held: in_ready = !(out_valid && !out_ready).
module cordic_stream_top
  import cordic_pkg::*;
#(
  parameter int DW   = 32,
  parameter int FRAC = 28,
  parameter int ITER = 16,
  parameter int TAGW = 4,
  parameter int GB   = 2
) (
  input logic            clk,
  input logic            rst_n,
  cordic_stream_if.slave io
);
  localparam int     W      = DW + GB;
  localparam longint PI_L   = pi_fx(FRAC);
  localparam longint HPI_L  = half_pi_fx(FRAC);
  localparam longint KINV_L = k_inv(FRAC);
  localparam logic signed [W-1:0] PI_W   = PI_L[W-1:0];
  localparam logic signed [W-1:0] HPI_W  = HPI_L[W-1:0];
  localparam logic signed [W-1:0] KINV_W = KINV_L[W-1:0];

  logic en;
  assign en          = !(io.out_valid && !io.out_ready);
  assign io.in_ready = en;

  logic signed [W-1:0] ix, iy, iz, px, py, pz;
  logic                pflip;

  assign ix = {{GB{io.in_x[DW-1]}}, io.in_x};
  assign iy = {{GB{io.in_y[DW-1]}}, io.in_y};
  assign iz = {{GB{io.in_z[DW-1]}}, io.in_z};

  // flip: rotation modes negate the result; vectoring forces a zero result.
  always_comb begin
    px    = '0;
    py    = '0;
    pz    = '0;
    pflip = 1'b0;
    case (io.in_mode)
      CORDIC_SINCOS, CORDIC_ROT: begin
        px = (io.in_mode == CORDIC_SINCOS) ? KINV_W : ix;
        py = (io.in_mode == CORDIC_SINCOS) ? '0 : iy;
        pz = iz;
        if (iz > HPI_W) begin
          pz    = iz - PI_W;
          pflip = 1'b1;
        end else if (iz < -HPI_W) begin
          pz    = iz + PI_W;
          pflip = 1'b1;
        end
      end
      CORDIC_VECT: begin
        px = ix;
        py = iy;
        if (ix == '0 && iy == '0) begin
          pflip = 1'b1;
        end else if (ix[W-1]) begin
          // Mirror into the right half plane; z starts at the +/-pi correction.
          px = -ix;
          py = -iy;
          pz = iy[W-1] ? -PI_W : PI_W;
        end
      end
      default: ;
    endcase
  end

  logic                s0_valid;
  cordic_mode_t        s0_mode;
  logic                s0_flip;
  logic [TAGW-1:0]     s0_tag;
  logic signed [W-1:0] s0_x, s0_y, s0_z;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
    end else if (en) begin
      s0_valid <= io.in_valid;
      s0_mode  <= io.in_mode;
      s0_flip  <= pflip;
      s0_tag   <= io.in_tag;
      s0_x     <= px;
      s0_y     <= py;
      s0_z     <= pz;
    end
  end

  logic                stg_valid [ITER+1];
  cordic_mode_t        stg_mode  [ITER+1];
  logic                stg_flip  [ITER+1];
  logic [TAGW-1:0]     stg_tag   [ITER+1];
  logic signed [W-1:0] stg_x     [ITER+1];
  logic signed [W-1:0] stg_y     [ITER+1];
  logic signed [W-1:0] stg_z     [ITER+1];

  assign stg_valid[0] = s0_valid;
  assign stg_mode[0]  = s0_mode;
  assign stg_flip[0]  = s0_flip;
  assign stg_tag[0]   = s0_tag;
  assign stg_x[0]     = s0_x;
  assign stg_y[0]     = s0_y;
  assign stg_z[0]     = s0_z;

  for (genvar i = 0; i < ITER; i++) begin : g_iter
    localparam longint ATAN_I = atan_lut(i, FRAC, W);
    cordic_iter_stage #(
      .W(W), .SHIFT(i), .ATAN(ATAN_I[W-1:0]), .TAGW(TAGW)
    ) u_iter (
      .clk(clk), .rst_n(rst_n), .en(en),
      .prev_valid(stg_valid[i]), .prev_mode(stg_mode[i]), .prev_flip(stg_flip[i]),
      .prev_tag(stg_tag[i]), .prev_x(stg_x[i]), .prev_y(stg_y[i]), .prev_z(stg_z[i]),
      .next_valid(stg_valid[i+1]), .next_mode(stg_mode[i+1]), .next_flip(stg_flip[i+1]),
      .next_tag(stg_tag[i+1]), .next_x(stg_x[i+1]), .next_y(stg_y[i+1]), .next_z(stg_z[i+1])
    );
  end

  // Drop the guard bits, clamping when they disagree with the new sign bit.
  function automatic logic [DW-1:0] sat(input logic signed [W-1:0] v);
    if ((&v[W-1:DW-1]) || !(|v[W-1:DW-1])) return v[DW-1:0];
    return v[W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  logic [DW-1:0] res_a, res_b;
  logic          res_err;

  always_comb begin
    res_a   = '0;
    res_b   = '0;
    res_err = 1'b0;
    case (stg_mode[ITER])
      CORDIC_SINCOS, CORDIC_ROT: begin
        res_a = sat(stg_flip[ITER] ? -stg_x[ITER] : stg_x[ITER]);
        res_b = sat(stg_flip[ITER] ? -stg_y[ITER] : stg_y[ITER]);
      end
      CORDIC_VECT: begin
        if (!stg_flip[ITER]) begin
          res_a = sat(stg_x[ITER]);
          res_b = sat(stg_z[ITER]);
        end
      end
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.out_a     <= '0;
      io.out_b     <= '0;
      io.out_tag   <= '0;
      io.out_err   <= 1'b0;
    end else if (en) begin
      io.out_valid <= stg_valid[ITER];
      io.out_a     <= res_a;
      io.out_b     <= res_b;
      io.out_tag   <= stg_tag[ITER];
      io.out_err   <= res_err;
    end
  end

  logic busy_any;
  always_comb begin
    busy_any = io.out_valid;
    for (int i = 0; i <= ITER; i++) busy_any = busy_any | stg_valid[i];
  end
  assign io.busy = busy_any;
endmodule
